// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streams a word-aligned message from memory as 512-bit
// SHA-256 blocks (16 x 32-bit words), appending the 0x80 pad word, zero fill
// and the 64-bit bit length.
// Optional build macro: SHA256_PAD_BYTESWAP_EN byte-reverses message words
// read from memory. Pad and length words are never swapped.
module sha256_msg_padder #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_message_addr,
  input  logic [LEN_W-1:0]  i_num_words,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [31:0]       i_mem_read_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_data,
  output logic [3:0]        o_out_idx,
  output logic              o_out_blk_last,
  output logic              o_out_msg_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_HOLD    = 3'd3,
    S_EMIT    = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [LEN_W:0]    r_g, w_g_nxt, w_g1;
  logic [LEN_W:0]    r_last, w_last_nxt;
  logic [LEN_W-1:0]  r_n, w_n_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              r_mem_re, w_re_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic              r_out_valid, w_valid_nxt;
  logic [31:0]       r_out_data, w_data_nxt;
  logic [3:0]        r_out_idx, w_idx_nxt;
  logic              r_out_blk_last, w_blk_last_nxt;
  logic              r_out_msg_last, w_msg_last_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_hs;

  // Index of the final stream word: 16*B-1 with B = (n+2)/16 + 1.
  function automatic logic [LEN_W:0] last_g_of(input logic [LEN_W-1:0] n);
    logic [LEN_W:0] s;
    s = {1'b0, n} + {{(LEN_W-1){1'b0}}, 2'b10};
    return {s[LEN_W:4], 4'hF};
  endfunction

  // Generated (non-memory) word for stream position g.
  function automatic logic [31:0] gen_word(input logic [LEN_W:0] g,
                                           input logic [LEN_W-1:0] n,
                                           input logic [LEN_W:0] last);
    logic [63:0] len_bits;
    len_bits = {{(64-LEN_W-5){1'b0}}, n, 5'b00000};
    if (g == {1'b0, n})
      return 32'h8000_0000;
    else if (g == (last - {{LEN_W{1'b0}}, 1'b1}))
      return len_bits[63:32];
    else if (g == last)
      return len_bits[31:0];
    else
      return 32'h0000_0000;
  endfunction

  // Message word as presented on the output stream.
  function automatic logic [31:0] msg_word(input logic [31:0] d);
`ifdef SHA256_PAD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  assign w_hs = r_out_valid && i_out_ready;
  assign w_g1 = r_g + {{LEN_W{1'b0}}, 1'b1};

  // Next-state and next-output computation; all outputs are registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_g_nxt        = r_g;
    w_n_nxt        = r_n;
    w_base_nxt     = r_base;
    w_last_nxt     = r_last;
    w_re_nxt       = 1'b0;
    w_addr_nxt     = r_mem_addr;
    w_valid_nxt    = r_out_valid;
    w_data_nxt     = r_out_data;
    w_idx_nxt      = r_out_idx;
    w_blk_last_nxt = r_out_blk_last;
    w_msg_last_nxt = r_out_msg_last;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_n_nxt    = i_num_words;
          w_base_nxt = i_message_addr;
          w_last_nxt = last_g_of(i_num_words);
          w_g_nxt    = '0;
          w_busy_nxt = 1'b1;
          if (i_num_words != '0) begin
            w_state_nxt = S_RD_REQ;
            w_re_nxt    = 1'b1;
            w_addr_nxt  = i_message_addr;
          end else begin
            w_state_nxt    = S_EMIT;
            w_valid_nxt    = 1'b1;
            w_data_nxt     = 32'h8000_0000;
            w_idx_nxt      = 4'd0;
            w_blk_last_nxt = 1'b0;
            w_msg_last_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_REQ: begin
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_state_nxt    = S_HOLD;
        w_valid_nxt    = 1'b1;
        w_data_nxt     = msg_word(i_mem_read_data);
        w_idx_nxt      = r_g[3:0];
        w_blk_last_nxt = (r_g[3:0] == 4'hF);
        w_msg_last_nxt = (r_g == r_last);
      end
      S_HOLD, S_EMIT: begin
        if (w_hs) begin
          if (r_g == r_last) begin
            w_state_nxt = S_FIN;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (w_g1 < {1'b0, r_n}) begin
            w_state_nxt = S_RD_REQ;
            w_g_nxt     = w_g1;
            w_valid_nxt = 1'b0;
            w_re_nxt    = 1'b1;
            w_addr_nxt  = r_base + ADDR_W'(w_g1);
          end else begin
            w_state_nxt    = S_EMIT;
            w_g_nxt        = w_g1;
            w_valid_nxt    = 1'b1;
            w_data_nxt     = gen_word(w_g1, r_n, r_last);
            w_idx_nxt      = w_g1[3:0];
            w_blk_last_nxt = (w_g1[3:0] == 4'hF);
            w_msg_last_nxt = (w_g1 == r_last);
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Counters, captured request parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_g            <= '0;
      r_n            <= '0;
      r_base         <= '0;
      r_last         <= '0;
      r_mem_re       <= 1'b0;
      r_mem_addr     <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= 32'h0000_0000;
      r_out_idx      <= 4'd0;
      r_out_blk_last <= 1'b0;
      r_out_msg_last <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_g            <= w_g_nxt;
      r_n            <= w_n_nxt;
      r_base         <= w_base_nxt;
      r_last         <= w_last_nxt;
      r_mem_re       <= w_re_nxt;
      r_mem_addr     <= w_addr_nxt;
      r_out_valid    <= w_valid_nxt;
      r_out_data     <= w_data_nxt;
      r_out_idx      <= w_idx_nxt;
      r_out_blk_last <= w_blk_last_nxt;
      r_out_msg_last <= w_msg_last_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
    end
  end

  assign o_mem_re       = r_mem_re;
  assign o_mem_addr     = r_mem_addr;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_out_idx      = r_out_idx;
  assign o_out_blk_last = r_out_blk_last;
  assign o_out_msg_last = r_out_msg_last;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: table of message lengths and
// addresses, scoreboard of expected stream words, plus a mid-stream reset.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = 16'h0000;
  logic [15:0] num_words = 16'h0000;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_read_data = 32'h0000_0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_blk_last;
  logic        out_msg_last;
  logic        busy;
  logic        done;

  sha256_msg_padder #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start),
    .i_message_addr(message_addr), .i_num_words(num_words),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .i_mem_read_data(mem_read_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_idx(out_idx), .o_out_blk_last(out_blk_last),
    .o_out_msg_last(out_msg_last), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // Memory model with one-cycle read latency and a read-strobe counter.
  logic [31:0] mem [0:65535];
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_re) begin
      mem_read_data <= mem[mem_addr];
      rd_cnt = rd_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        bl;
    logic        ml;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    int          n;
    logic [15:0] addr;
    bit          rnd;
    bit          poke;
    int          exp_words;
    logic [31:0] exp_last;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [31:0] model_mem(input logic [31:0] d);
`ifdef SHA256_PAD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    int blocks, total, words, rd0, cyc;
    bit done_seen, prev_final, prev_stall;
    logic [31:0] last_data, st_data;
    logic [3:0]  st_idx;
    logic [63:0] len_bits;
    word_t w, e;
    exp_q.delete();
    blocks = (v.n + 2) / 16 + 1;
    total = 16 * blocks;
    len_bits = 64'(v.n) * 64'd32;
    for (int g = 0; g < total; g++) begin
      if (g < v.n) begin
        logic [15:0] a;
        a = v.addr + 16'(g);
        w.data = model_mem(mem[a]);
      end
      else if (g == v.n)        w.data = 32'h8000_0000;
      else if (g == total - 2)  w.data = len_bits[63:32];
      else if (g == total - 1)  w.data = len_bits[31:0];
      else                      w.data = 32'h0000_0000;
      w.idx = 4'(g % 16);
      w.bl  = (g % 16 == 15);
      w.ml  = (g == total - 1);
      exp_q.push_back(w);
    end
    words = 0; done_seen = 1'b0; prev_final = 1'b0; prev_stall = 1'b0;
    last_data = 32'h0; st_data = 32'h0; st_idx = 4'h0;
    @(posedge clk); #1;
    out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1; num_words = 16'(v.n); message_addr = v.addr;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check(busy == 1'b1, "busy_after_start", 64'(busy), 64'd1);
      if (prev_stall)
        check(out_valid && out_data == st_data && out_idx == st_idx, "stall_stable",
              {27'd0, out_valid, out_idx, out_data}, {27'd0, 1'b1, st_idx, st_data});
      if (done) begin
        check(prev_final && !busy, "done_after_final", {62'd0, prev_final, busy}, 64'd2);
        done_seen = 1'b1;
        break;
      end
      prev_final = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "extra_word", 64'(out_data), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check(out_data == e.data && out_idx == e.idx && out_blk_last == e.bl && out_msg_last == e.ml,
                $sformatf("word_n%0d_g%0d", v.n, words),
                {26'd0, out_blk_last, out_msg_last, out_idx, out_data},
                {26'd0, e.bl, e.ml, e.idx, e.data});
          prev_final = e.ml;
        end
        words++;
        last_data = out_data;
      end
      prev_stall = out_valid && !out_ready;
      st_data = out_data; st_idx = out_idx;
      @(posedge clk); #1;
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = v.poke && (cyc == 5);
      if (start) num_words = 16'd7;
    end
    start = 1'b0;
    check(done_seen, "done_timeout", 64'(done_seen), 64'd1);
    check(words == v.exp_words, "word_count", 64'(words), 64'(v.exp_words));
    check(rd_cnt - rd0 == v.n, "read_count", 64'(rd_cnt - rd0), 64'(v.n));
    check(last_data == v.exp_last, "length_word", 64'(last_data), 64'(v.exp_last));
    @(negedge clk);
    check(!done && !busy && !out_valid, "idle_after_done", {61'd0, done, busy, out_valid}, 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'(i) ^ 16'hC3A5, 16'(i)};
    mem[16'h0040] = 32'h6162_6364;
    vecs[0] = '{n: 0,  addr: 16'h0000, rnd: 1'b0, poke: 1'b0, exp_words: 16, exp_last: 32'h0000_0000};
    vecs[1] = '{n: 1,  addr: 16'h0040, rnd: 1'b0, poke: 1'b0, exp_words: 16, exp_last: 32'h0000_0020};
    vecs[2] = '{n: 13, addr: 16'h0100, rnd: 1'b0, poke: 1'b1, exp_words: 16, exp_last: 32'h0000_01A0};
    vecs[3] = '{n: 14, addr: 16'h0200, rnd: 1'b0, poke: 1'b0, exp_words: 32, exp_last: 32'h0000_01C0};
    vecs[4] = '{n: 15, addr: 16'h0300, rnd: 1'b0, poke: 1'b0, exp_words: 32, exp_last: 32'h0000_01E0};
    vecs[5] = '{n: 20, addr: 16'hFFFE, rnd: 1'b0, poke: 1'b0, exp_words: 32, exp_last: 32'h0000_0280};
    vecs[6] = '{n: 20, addr: 16'hFFFE, rnd: 1'b1, poke: 1'b0, exp_words: 32, exp_last: 32'h0000_0280};

    // Reset state.
    #2;
    check(!out_valid && !mem_re && !busy && !done && out_data == 32'h0 && out_idx == 4'h0,
          "reset_outputs", {56'd0, out_valid, mem_re, busy, done, out_idx}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during block 0 word 7, then a clean N=1 run.
    @(posedge clk); #1;
    out_ready = 1'b1; start = 1'b1; num_words = 16'd20; message_addr = 16'h0000;
    @(posedge clk); #1 start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(negedge clk);
        if (out_valid && out_idx == 4'd7) hit = 1'b1;
      end
      check(hit, "reach_word7", 64'(hit), 64'd1);
    end
    reset_n = 1'b0;
    #1;
    check(!out_valid && !busy && !done && !mem_re, "async_reset_mid",
          {60'd0, out_valid, busy, done, mem_re}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check(!done && !out_valid, "no_done_in_reset", {62'd0, done, out_valid}, 64'd0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
